time_set_ctrl: RTL and testbench

- Mode controller that sits between the debounced key classifier and the six-digit time counter and display.
- Takes the single-cycle short and long press pulses from key1 and key0 and sequences run / set-time / set-alarm modes.
- Selects the digit being edited, issues per-digit increment strobes, and drives the digit twinkle mask and valid_sd.
- Emits commit or abort strobes so the time counter and alarm register load or discard the edited value.

---
 rtl/time_set_ctrl_pkg.sv | 30 +++
 rtl/time_set_ctrl_tick_gen.sv | 29 ++
 rtl/time_set_ctrl.sv | 168 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_ctrl_pkg.sv
// Shared encodings for the time-setting controller: mode values, digit indices,
// simulation timebase overrides and the digit one-hot helper.
package time_set_ctrl_pkg;

  localparam logic [1:0] MODE_RUN       = 2'b00;
  localparam logic [1:0] MODE_SET_TIME  = 2'b01;
  localparam logic [1:0] MODE_SET_ALARM = 2'b10;

  typedef enum logic [1:0] {
    StRun      = MODE_RUN,
    StSetTime  = MODE_SET_TIME,
    StSetAlarm = MODE_SET_ALARM
  } mode_e;

  // Digit indices, most significant (hour tens) first.
  localparam logic [2:0] DIG_HT = 3'd5;
  localparam logic [2:0] DIG_HU = 3'd4;
  localparam logic [2:0] DIG_MT = 3'd3;
  localparam logic [2:0] DIG_MU = 3'd2;
  localparam logic [2:0] DIG_ST = 3'd1;
  localparam logic [2:0] DIG_SU = 3'd0;

  localparam int unsigned SIM_CNT_1S     = 50;
  localparam int unsigned SIM_BLINK_HALF = 25;

  function automatic logic [5:0] dig_onehot(input logic [2:0] dig);
    return 6'(6'b1 << dig);
  endfunction

endpackage

// File: rtl/time_set_ctrl_tick_gen.sv
// Free-running 0..Term-1 counter with synchronous clear; wrap is high while the
// counter sits on its terminal value.
module time_set_ctrl_tick_gen #(
  parameter int unsigned Term = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned W = (Term > 1) ? $clog2(Term) : 1;
  localparam logic [W-1:0] Last = W'(Term - 1);

  logic [W-1:0] cnt_q;

  assign wrap = (cnt_q == Last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == Last)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Run / set-time / set-alarm mode sequencer driven by key press pulses.
// Define ALARM_SET_EN to enable the set-alarm mode and commit_alarm strobe.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned CNT_1S     = 50_000_000,
  parameter int unsigned BLINK_HALF = 25_000_000,
  parameter int unsigned TIMEOUT_S  = 10
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       long_pression1,
  input  logic       short_pression1,
  input  logic       long_pression0,
  input  logic       short_pression0,
  output logic [1:0] mode,
  output logic       valid_sd,
  output logic [5:0] twinkle,
  output logic [5:0] inc_en,
  output logic       commit_time,
  output logic       commit_alarm,
  output logic       abort
);

  localparam int unsigned IdleW = $clog2(TIMEOUT_S + 1);

  mode_e            state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic             phase_q, phase_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [5:0]       twinkle_d, inc_d;
  logic             commit_time_d, abort_d;
  logic             blink_clr, blink_wrap, sec_clr, sec_wrap;

  time_set_ctrl_tick_gen #(
    .Term (BLINK_HALF)
  ) u_blink_tick (
    .clk   (sysclk),
    .rst_n (rst_n),
    .clr   (blink_clr),
    .wrap  (blink_wrap)
  );

  time_set_ctrl_tick_gen #(
    .Term (CNT_1S)
  ) u_sec_tick (
    .clk   (sysclk),
    .rst_n (rst_n),
    .clr   (sec_clr),
    .wrap  (sec_wrap)
  );

`ifdef ALARM_SET_EN
  logic commit_alarm_d;
`endif

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    idle_d        = idle_q;
    inc_d         = '0;
    commit_time_d = 1'b0;
    abort_d       = 1'b0;
    blink_clr     = 1'b0;
    sec_clr       = 1'b0;
`ifdef ALARM_SET_EN
    commit_alarm_d = 1'b0;
`endif
    unique case (state_q)
      StRun: begin
        // Timebases held cleared so every set-mode entry starts fresh.
        blink_clr = 1'b1;
        sec_clr   = 1'b1;
        idle_d    = '0;
        sel_d     = DIG_HT;
        if (long_pression1) begin
          state_d = StSetTime;
        end
`ifdef ALARM_SET_EN
        else if (long_pression0) begin
          state_d = StSetAlarm;
        end
`endif
      end
      StSetTime, StSetAlarm: begin
        if (short_pression0) begin
          state_d = StRun;
          sec_clr = 1'b1;
          idle_d  = '0;
`ifdef ALARM_SET_EN
          if (state_q == StSetAlarm) commit_alarm_d = 1'b1;
          else commit_time_d = 1'b1;
`else
          commit_time_d = 1'b1;
`endif
        end else if (long_pression1) begin
          inc_d   = dig_onehot(sel_q);
          sec_clr = 1'b1;
          idle_d  = '0;
        end else if (short_pression1) begin
          sel_d     = (sel_q == DIG_SU) ? DIG_HT : sel_q - 3'd1;
          blink_clr = 1'b1;
          sec_clr   = 1'b1;
          idle_d    = '0;
        end else if (idle_q == IdleW'(TIMEOUT_S)) begin
          state_d = StRun;
          abort_d = 1'b1;
        end else if (sec_wrap) begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Kept apart from the FSM block so the tick wrap never feeds back into its clear.
  always_comb begin
    phase_d = phase_q;
    if (blink_clr) begin
      phase_d = 1'b0;
    end else if (blink_wrap) begin
      phase_d = ~phase_q;
    end
    twinkle_d = '0;
    if ((state_d != StRun) && !phase_d) begin
      twinkle_d = dig_onehot(sel_d);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      sel_q       <= DIG_HT;
      phase_q     <= 1'b0;
      idle_q      <= '0;
      valid_sd    <= 1'b1;
      twinkle     <= '0;
      inc_en      <= '0;
      commit_time <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      phase_q     <= phase_d;
      idle_q      <= idle_d;
      valid_sd    <= (state_d == StRun);
      twinkle     <= twinkle_d;
      inc_en      <= inc_d;
      commit_time <= commit_time_d;
      abort       <= abort_d;
    end
  end

`ifdef ALARM_SET_EN
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      commit_alarm <= 1'b0;
    end else begin
      commit_alarm <= commit_alarm_d;
    end
  end
`else
  assign commit_alarm = 1'b0;
`endif

  assign mode = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus randomized key
// pulses, compared cycle by cycle against an elapsed-time reference model.
module tb_time_set_ctrl;

  localparam int unsigned CNT = 50;
  localparam int unsigned BH  = 25;
  localparam int unsigned TO  = 10;
`ifdef ALARM_SET_EN
  localparam bit AlarmEn = 1'b1;
`else
  localparam bit AlarmEn = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       long_pression1, short_pression1, long_pression0, short_pression0;
  logic [1:0] mode;
  logic       valid_sd;
  logic [5:0] twinkle, inc_en;
  logic       commit_time, commit_alarm, abort;

  always #5 sysclk = ~sysclk;

  time_set_ctrl #(
    .CNT_1S     (CNT),
    .BLINK_HALF (BH),
    .TIMEOUT_S  (TO)
  ) dut (
    .sysclk          (sysclk),
    .rst_n           (rst_n),
    .long_pression1  (long_pression1),
    .short_pression1 (short_pression1),
    .long_pression0  (long_pression0),
    .short_pression0 (short_pression0),
    .mode            (mode),
    .valid_sd        (valid_sd),
    .twinkle         (twinkle),
    .inc_en          (inc_en),
    .commit_time     (commit_time),
    .commit_alarm    (commit_alarm),
    .abort           (abort)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: mode, selected digit, edges since blink restart and since
  // last accepted activity, plus the strobes expected after the latest edge.
  int       m_mode, m_sel, m_bt, m_it;
  logic [5:0] e_inc;
  logic     e_ct, e_ca, e_ab;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_sel  = 5;
    m_bt   = 0;
    m_it   = 0;
    e_inc  = '0;
    e_ct   = 1'b0;
    e_ca   = 1'b0;
    e_ab   = 1'b0;
  endtask

  task automatic model_enter(input int new_mode);
    m_mode = new_mode;
    m_sel  = 5;
    m_bt   = 0;
    m_it   = 0;
  endtask

  task automatic model_step(input bit s0, input bit l1, input bit s1, input bit l0);
    e_inc = '0;
    e_ct  = 1'b0;
    e_ca  = 1'b0;
    e_ab  = 1'b0;
    if (m_mode == 0) begin
      if (l1) model_enter(1);
      else if (AlarmEn && l0) model_enter(2);
    end else if (s0) begin
      if (m_mode == 2) e_ca = 1'b1;
      else e_ct = 1'b1;
      m_mode = 0;
    end else if (l1) begin
      e_inc = 6'(1 << m_sel);
      m_it  = 0;
      m_bt++;
    end else if (s1) begin
      m_sel = (m_sel == 0) ? 5 : m_sel - 1;
      m_bt  = 0;
      m_it  = 0;
    end else if (m_it == int'(TO * CNT)) begin
      e_ab   = 1'b1;
      m_mode = 0;
    end else begin
      m_it++;
      m_bt++;
    end
  endtask

  function automatic logic [5:0] exp_twinkle();
    if (m_mode == 0 || ((m_bt / int'(BH)) % 2) != 0) return '0;
    return 6'(1 << m_sel);
  endfunction

  task automatic check_outputs();
    check_eq("mode", 32'(mode), 32'(m_mode));
    check_eq("valid_sd", 32'(valid_sd), 32'(m_mode == 0));
    check_eq("twinkle", 32'(twinkle), 32'(exp_twinkle()));
    check_eq("inc_en", 32'(inc_en), 32'(e_inc));
    check_eq("strobes", 32'({commit_time, commit_alarm, abort}), 32'({e_ct, e_ca, e_ab}));
  endtask

  // Called at a negedge: drive one cycle of pulses, pass the rising edge, check.
  task automatic cycle(input bit s0, input bit l1, input bit s1, input bit l0);
    short_pression0 = s0;
    long_pression1  = l1;
    short_pression1 = s1;
    long_pression0  = l0;
    model_step(s0, l1, s1, l0);
    @(negedge sysclk);
    short_pression0 = 1'b0;
    long_pression1  = 1'b0;
    short_pression1 = 1'b0;
    long_pression0  = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_mode"}, 32'(mode), 32'd0);
    check_eq({tag, "_valid_sd"}, 32'(valid_sd), 32'd1);
    check_eq({tag, "_twinkle"}, 32'(twinkle), 32'd0);
    check_eq({tag, "_inc_en"}, 32'(inc_en), 32'd0);
    check_eq({tag, "_strobes"}, 32'({commit_time, commit_alarm, abort}), 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    short_pression0 = 1'b0;
    long_pression1  = 1'b0;
    short_pression1 = 1'b0;
    long_pression0  = 1'b0;
    model_reset();
    repeat (2) @(negedge sysclk);
    check_reset_state("reset");
    rst_n = 1'b1;
    idle(200);

    // Enter set-time, walk sel 5->4->3, increment digit 3, watch the blink.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("inc_digit3", 32'(inc_en), 32'h08);
    idle(80);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("commit_time_exit", 32'(commit_time), 32'd1);

    // Alarm entry (no-op without the alarm feature), sel wrap, commit.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
    end
    idle(30);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Idle timeout aborts the edit.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(520);
    check_eq("timeout_mode", 32'(mode), 32'd0);

    // A press just before the deadline restarts the idle count.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(499);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(450);
    check_eq("restart_mode", 32'(mode), 32'd1);

    // Commit beats increment in the same cycle.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Asynchronous reset mid-edit.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    model_reset();
    @(negedge sysclk);
    check_reset_state("rst_hold");
    rst_n = 1'b1;
    idle(5);

    // Randomized pulses, each round ending in a long idle stretch.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 400; i++) begin
        cycle($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
      end
      idle(520);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
